// File: rtl/vga_pattern_scheduler_pkg.sv
//==============================================================================
// Module   : vga_sched_pkg
// Brief    : Selection/mode encodings and auto-rotation helper for the scheduler.
// Revision : 1.0
//==============================================================================
`default_nettype none

package vga_sched_pkg;

   localparam logic [1:0] SEL_SRC2  = 2'd0;
   localparam logic [1:0] SEL_SRC1  = 2'd1;
   localparam logic [1:0] SEL_BLEND = 2'd2;

   // Requested mode as decoded from the accepted levels {sw2, sw1}
   typedef enum logic [1:0] {
      MODE_SRC2  = 2'b00,
      MODE_SRC1  = 2'b01,
      MODE_BLEND = 2'b10,
      MODE_AUTO  = 2'b11
   } mode_t;

   function automatic logic [1:0] next_auto_sel(input logic [1:0] sel);
      logic [1:0] nxt;
      case (sel)
         SEL_SRC1:  nxt = SEL_SRC2;
         SEL_SRC2:  nxt = SEL_BLEND;
         SEL_BLEND: nxt = SEL_SRC1;
         default:   nxt = SEL_SRC1;
      endcase
      return nxt;
   endfunction

endpackage

`default_nettype wire

// File: rtl/vga_pattern_scheduler_if.sv
//==============================================================================
// Module   : vga_pattern_scheduler_if
// Brief    : Pixel-side bundle between vgaDriver/pattern generators and scheduler.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface vga_pattern_scheduler_if;

   logic [8:0] row_i;
   logic [9:0] column_i;
   logic [2:0] rgbmod1_i;
   logic [2:0] rgbmod2_i;
   logic [2:0] rgb_o;
   logic [1:0] sel_o;
   logic       auto_o;
   logic       frame_start_o;

   modport master (
      output row_i, column_i, rgbmod1_i, rgbmod2_i,
      input  rgb_o, sel_o, auto_o, frame_start_o
   );

   modport slave (
      input  row_i, column_i, rgbmod1_i, rgbmod2_i,
      output rgb_o, sel_o, auto_o, frame_start_o
   );

endinterface

`default_nettype wire

// File: rtl/switch_debounce.sv
//==============================================================================
// Module   : switch_debounce
// Brief    : 2-flop synchroniser plus hold-time debounce for one board switch.
// Revision : 1.0
//==============================================================================
`default_nettype none

module switch_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  wire logic clk_i,
   input  wire logic reset_ni,
   input  wire logic raw_i,
   output logic      level_o
);

   localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_a;
   logic             sync_b;
   logic             level;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
         level  <= 1'b0;
         cnt    <= '0;
      end else begin
         sync_a <= raw_i;
         sync_b <= sync_a;
         // Any return to the accepted level restarts the hold window
         if (sync_b == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync_b;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign level_o = level;

endmodule

`default_nettype wire

// File: rtl/vga_pattern_scheduler.sv
//==============================================================================
// Module   : vga_pattern_scheduler
// Brief    : Frame-aligned pattern source selection with switch-driven modes.
// Revision : 1.0
//==============================================================================
`default_nettype none

module vga_pattern_scheduler
   import vga_sched_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int FRAMES_PER_STEP = 60
) (
   input  wire logic               clk_i,
   input  wire logic               reset_ni,
   input  wire logic               switch1_i,
   input  wire logic               switch2_i,
   vga_pattern_scheduler_if.slave  vga
);

   localparam int               FCNT_W    = $clog2(FRAMES_PER_STEP + 1);
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES_PER_STEP - 1);

   logic              level1;
   logic              level2;
   mode_t             mode;
   logic              origin;
   logic              origin_q;
   logic              frame_start;
   logic [1:0]        sel_q;
   logic              auto_q;
   logic [FCNT_W-1:0] frame_cnt;
   logic [2:0]        rgb;

   switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sw1 (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .raw_i    (switch1_i),
      .level_o  (level1)
   );

   switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sw2 (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .raw_i    (switch2_i),
      .level_o  (level2)
   );

   assign mode        = mode_t'({level2, level1});
   assign origin      = (vga.row_i == 9'd0) && (vga.column_i == 10'd0);
   // Edge-detect the origin so a driver holding 0/0 still yields one pulse
   assign frame_start = origin && !origin_q;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         origin_q  <= 1'b0;
         sel_q     <= SEL_SRC2;
         auto_q    <= 1'b0;
         frame_cnt <= '0;
      end else begin
         origin_q <= origin;
         if (frame_start) begin
            case (mode)
               MODE_SRC2: begin
                  sel_q     <= SEL_SRC2;
                  auto_q    <= 1'b0;
                  frame_cnt <= '0;
               end
               MODE_SRC1: begin
                  sel_q     <= SEL_SRC1;
                  auto_q    <= 1'b0;
                  frame_cnt <= '0;
               end
               MODE_BLEND: begin
                  sel_q     <= SEL_BLEND;
                  auto_q    <= 1'b0;
                  frame_cnt <= '0;
               end
               default: begin
                  if (!auto_q) begin
                     sel_q     <= SEL_SRC1;
                     auto_q    <= 1'b1;
                     frame_cnt <= '0;
                  end else if (frame_cnt == FCNT_LAST) begin
                     sel_q     <= next_auto_sel(sel_q);
                     frame_cnt <= '0;
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
            endcase
         end
      end
   end

   // Zero-latency mux keeps colour aligned with the driver's row/column
   always_comb begin
      rgb = vga.rgbmod2_i;
      case (sel_q)
         SEL_SRC1:  rgb = vga.rgbmod1_i;
         SEL_BLEND: rgb = vga.rgbmod1_i & vga.rgbmod2_i;
         default:   rgb = vga.rgbmod2_i;
      endcase
   end

   assign vga.rgb_o         = rgb;
   assign vga.sel_o         = sel_q;
   assign vga.auto_o        = auto_q;
   assign vga.frame_start_o = frame_start;

endmodule

`default_nettype wire

// File: tb/tb_vga_pattern_scheduler.sv
//==============================================================================
// Module   : tb_vga_pattern_scheduler
// Brief    : Directed self-checking bench for vga_pattern_scheduler.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_vga_pattern_scheduler;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic sw1     = 1'b0;
   logic sw2     = 1'b0;
   int   checks  = 0;
   int   errors  = 0;

   vga_pattern_scheduler_if vif ();

   vga_pattern_scheduler #(
      .DEBOUNCE_CYCLES (4),
      .FRAMES_PER_STEP (2)
   ) dut (
      .clk_i     (clk),
      .reset_ni  (reset_n),
      .switch1_i (sw1),
      .switch2_i (sw2),
      .vga       (vif)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One-cycle origin, then back to mid-frame; outputs settled on return
   task automatic origin();
      vif.row_i    = 9'd0;
      vif.column_i = 10'd0;
      step(1);
      vif.row_i    = 9'd100;
      vif.column_i = 10'd3;
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      step(2);
      checks++; if (vif.sel_o !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", vif.sel_o); end
      checks++; if (vif.auto_o !== 1'b0) begin errors++; $display("FAIL reset_auto got %0b want 0", vif.auto_o); end
      checks++; if (vif.frame_start_o !== 1'b0) begin errors++; $display("FAIL reset_fs got %0b want 0", vif.frame_start_o); end
      checks++; if (vif.rgb_o !== 3'b010) begin errors++; $display("FAIL reset_rgb got %b want 010", vif.rgb_o); end
      reset_n = 1'b1;
      step(2);
   endtask

   task automatic test_glitch();
      sw1 = 1'b1;
      step(3);
      sw1 = 1'b0;
      step(10);
      for (int i = 0; i < 3; i++) begin
         origin();
         checks++; if (vif.sel_o !== 2'd0) begin errors++; $display("FAIL glitch_sel[%0d] got %0d want 0", i, vif.sel_o); end
         step(3);
      end
      checks++; if (vif.auto_o !== 1'b0) begin errors++; $display("FAIL glitch_auto got %0b want 0", vif.auto_o); end
   endtask

   task automatic test_frame_align();
      sw1 = 1'b1;
      step(10);
      checks++; if (vif.sel_o !== 2'd0) begin errors++; $display("FAIL align_pre got %0d want 0", vif.sel_o); end
      vif.row_i    = 9'd0;
      vif.column_i = 10'd0;
      #1;
      checks++; if (vif.frame_start_o !== 1'b1) begin errors++; $display("FAIL align_fs got %0b want 1", vif.frame_start_o); end
      checks++; if (vif.sel_o !== 2'd0) begin errors++; $display("FAIL align_origin_sel got %0d want 0", vif.sel_o); end
      checks++; if (vif.rgb_o !== 3'b010) begin errors++; $display("FAIL align_origin_rgb got %b want 010", vif.rgb_o); end
      step(1);
      vif.column_i = 10'd1;
      #1;
      checks++; if (vif.frame_start_o !== 1'b0) begin errors++; $display("FAIL align_fs_end got %0b want 0", vif.frame_start_o); end
      checks++; if (vif.sel_o !== 2'd1) begin errors++; $display("FAIL align_sel got %0d want 1", vif.sel_o); end
      checks++; if (vif.rgb_o !== 3'b101) begin errors++; $display("FAIL align_rgb got %b want 101", vif.rgb_o); end
      vif.row_i = 9'd100;
      step(2);
   endtask

   task automatic test_blend();
      vif.rgbmod1_i = 3'b110;
      vif.rgbmod2_i = 3'b011;
      sw1 = 1'b0;
      sw2 = 1'b1;
      step(10);
      checks++; if (vif.rgb_o !== 3'b110) begin errors++; $display("FAIL blend_pre_rgb got %b want 110", vif.rgb_o); end
      origin();
      checks++; if (vif.sel_o !== 2'd2) begin errors++; $display("FAIL blend_sel got %0d want 2", vif.sel_o); end
      checks++; if (vif.rgb_o !== 3'b010) begin errors++; $display("FAIL blend_rgb got %b want 010", vif.rgb_o); end
      step(2);
   endtask

   task automatic test_auto_rotation();
      logic [1:0] exp_sel [7];
      exp_sel = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd1};
      sw1 = 1'b1;
      sw2 = 1'b1;
      step(10);
      for (int i = 0; i < 7; i++) begin
         origin();
         checks++; if (vif.sel_o !== exp_sel[i]) begin errors++; $display("FAIL auto_sel[%0d] got %0d want %0d", i, vif.sel_o, exp_sel[i]); end
         checks++; if (vif.auto_o !== 1'b1) begin errors++; $display("FAIL auto_flag[%0d] got %0b want 1", i, vif.auto_o); end
         step(3);
      end
   endtask

   task automatic test_held_origin();
      int pulses;
      pulses       = 0;
      vif.row_i    = 9'd0;
      vif.column_i = 10'd0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (vif.frame_start_o === 1'b1) pulses++;
         step(1);
      end
      vif.row_i    = 9'd100;
      vif.column_i = 10'd3;
      #1;
      checks++; if (pulses !== 1) begin errors++; $display("FAIL held_pulses got %0d want 1", pulses); end
      checks++; if (vif.sel_o !== 2'd1) begin errors++; $display("FAIL held_sel got %0d want 1", vif.sel_o); end
      step(2);
      origin();
      checks++; if (vif.sel_o !== 2'd0) begin errors++; $display("FAIL held_next_sel got %0d want 0", vif.sel_o); end
      step(2);
   endtask

   task automatic test_reset_mid_auto();
      origin();
      step(2);
      origin();
      checks++; if (vif.sel_o !== 2'd2) begin errors++; $display("FAIL rst_pre_sel got %0d want 2", vif.sel_o); end
      step(2);
      reset_n = 1'b0;
      #1;
      checks++; if (vif.sel_o !== 2'd0) begin errors++; $display("FAIL rst_sel got %0d want 0", vif.sel_o); end
      checks++; if (vif.auto_o !== 1'b0) begin errors++; $display("FAIL rst_auto got %0b want 0", vif.auto_o); end
      checks++; if (vif.rgb_o !== 3'b011) begin errors++; $display("FAIL rst_rgb got %b want 011", vif.rgb_o); end
      step(1);
      reset_n = 1'b1;
      step(2);
      origin();
      checks++; if (vif.sel_o !== 2'd0) begin errors++; $display("FAIL rst_early_sel got %0d want 0", vif.sel_o); end
      checks++; if (vif.auto_o !== 1'b0) begin errors++; $display("FAIL rst_early_auto got %0b want 0", vif.auto_o); end
      step(10);
      origin();
      checks++; if (vif.sel_o !== 2'd1) begin errors++; $display("FAIL rst_reentry_sel got %0d want 1", vif.sel_o); end
      checks++; if (vif.auto_o !== 1'b1) begin errors++; $display("FAIL rst_reentry_auto got %0b want 1", vif.auto_o); end
   endtask

   initial begin
      vif.row_i     = 9'd100;
      vif.column_i  = 10'd3;
      vif.rgbmod1_i = 3'b101;
      vif.rgbmod2_i = 3'b010;
      test_reset();
      test_glitch();
      test_frame_align();
      test_blend();
      test_auto_rotation();
      test_held_origin();
      test_reset_mid_auto();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
